// File: rtl/axis_mux_pkg.sv
// Shared types and default sizes for the AXI-Stream packet multiplexer.
package axis_mux_pkg;

    typedef enum logic {
        IDLE,
        XFER
    } mux_state_t;

    localparam int AXIS_DATA_W_DEF = 8;
    localparam int AXIS_NUM_CH_DEF = 4;

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel after ptr, with wrap-around.
module axis_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    // Distance k = 1 is searched first, so the channel just served ranks last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_valid && req[i] && (i == (int'(ptr) + k) % NUM_CH)) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/axis_pkt_mux.sv
// N-input AXI-Stream packet mux with per-packet grant lock and a registered output slice.
// AXIS_PKT_MUX_RR_EN selects round-robin arbitration; otherwise the sel port picks the channel.
//
//   state | meaning
//   IDLE  | no grant held; arbitrate each cycle, all s_ready low
//   XFER  | cur_ch locked until its s_last beat is accepted
module axis_pkt_mux
    import axis_mux_pkg::*;
#(
    parameter int NUM_CH = AXIS_NUM_CH_DEF,
    parameter int DATA_W = AXIS_DATA_W_DEF,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    input  logic [NUM_CH-1:0]        s_valid,
    output logic [NUM_CH-1:0]        s_ready,
    input  logic [NUM_CH-1:0]        s_last,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [SEL_W-1:0]         cur_ch,
    output logic                     busy
);

    mux_state_t        state_q, state_d;
    logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
    logic [SEL_W-1:0]  cand;
    logic              cand_ok;
    logic              cur_valid, cur_last;
    logic [DATA_W-1:0] cur_data;
    logic              out_free, accept;

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_ch_q == SEL_W'(i)) begin
                cur_valid = s_valid[i];
                cur_last  = s_last[i];
                cur_data  = s_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign out_free = !m_valid || m_ready;
    assign accept   = (state_q == XFER) && cur_valid && out_free;

`ifdef AXIS_PKT_MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr_q;
    logic             unused_sel;

    assign unused_sel = ^sel;

    axis_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req       (s_valid),
        .ptr       (rr_ptr_q),
        .gnt_idx   (cand),
        .gnt_valid (cand_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= SEL_W'(NUM_CH - 1);
        end else if (state_q == IDLE && cand_ok) begin
            rr_ptr_q <= cand;
        end
    end
`else
    // An out-of-range sel matches no channel and so never grants.
    always_comb begin
        cand    = sel;
        cand_ok = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                cand_ok = s_valid[i];
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        case (state_q)
            IDLE: begin
                if (cand_ok) begin
                    state_d  = XFER;
                    cur_ch_d = cand;
                end
            end
            XFER: begin
                if (accept && cur_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_q == XFER && cur_ch_q == SEL_W'(i)) begin
                s_ready[i] = out_free;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cur_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= cur_data;
            m_last  <= cur_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    assign busy   = (state_q == XFER);
    assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_axis_pkt_mux.sv
// Directed bench for axis_pkt_mux; with AXIS_PKT_MUX_RR_EN defined it runs the round-robin sequence.
module tb_axis_pkt_mux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH*DATA_W-1:0] s_data;
    logic [NUM_CH-1:0]        s_valid;
    logic [NUM_CH-1:0]        s_ready;
    logic [NUM_CH-1:0]        s_last;
    logic [DATA_W-1:0]        m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_last;
    logic [SEL_W-1:0]         cur_ch;
    logic                     busy;

    int vectors     = 0;
    int miscompares = 0;

    axis_pkt_mux #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_last  (s_last),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .cur_ch  (cur_ch),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
        s_valid[ch]               = v;
        s_data[ch*DATA_W +: DATA_W] = d;
        s_last[ch]                = l;
    endtask

    logic [7:0] dbeat [5];

    initial begin
        reset   = 1'b0;
        sel     = '0;
        s_data  = '0;
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b1;
        dbeat   = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};

        #12;
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_data",  32'(m_data),  32'h0);
        chk("rst_m_last",  32'(m_last),  32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h0);
        chk("rst_cur_ch",  32'(cur_ch),  32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        reset = 1'b1;

`ifdef AXIS_PKT_MUX_RR_EN
        sel = 3'd2;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 8'(8'h10 + i), 1'b1);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("rr_grant_ch", 32'(cur_ch), 32'(n % NUM_CH));
            chk("rr_grant_busy", 32'(busy), 32'h1);
            tick();
            chk("rr_beat_data",  32'(m_data),  32'(8'h10 + (n % NUM_CH)));
            chk("rr_beat_last",  32'(m_last),  32'h1);
            chk("rr_beat_cur",   32'(cur_ch),  32'(n % NUM_CH));
            chk("rr_beat_valid", 32'(m_valid), 32'h1);
        end
        s_valid = '0;
`else
        // 3-beat packet on ch2
        sel = 3'd2;
        set_ch(2, 1'b1, 8'hA1, 1'b0);
        #1;
        chk("t1_idle_ready", 32'(s_ready), 32'h0);
        chk("t1_idle_busy",  32'(busy),    32'h0);
        tick();
        chk("t1_grant_busy",  32'(busy),    32'h1);
        chk("t1_grant_ch",    32'(cur_ch),  32'h2);
        chk("t1_grant_ready", 32'(s_ready), 32'h4);
        chk("t1_grant_mval",  32'(m_valid), 32'h0);
        tick();
        chk("t1_b1_data", 32'(m_data),  32'hA1);
        chk("t1_b1_val",  32'(m_valid), 32'h1);
        chk("t1_b1_last", 32'(m_last),  32'h0);
        chk("t1_b1_busy", 32'(busy),    32'h1);
        set_ch(2, 1'b1, 8'hA2, 1'b0);
        tick();
        chk("t1_b2_data", 32'(m_data), 32'hA2);
        chk("t1_b2_last", 32'(m_last), 32'h0);
        chk("t1_b2_busy", 32'(busy),   32'h1);
        set_ch(2, 1'b1, 8'hA3, 1'b1);
        tick();
        chk("t1_b3_data", 32'(m_data), 32'hA3);
        chk("t1_b3_last", 32'(m_last), 32'h1);
        chk("t1_b3_busy", 32'(busy),   32'h0);
        set_ch(2, 1'b0, 8'h00, 1'b0);
        tick();
        chk("t1_drain_val", 32'(m_valid), 32'h0);

        // sel switches to 0 while ch2 packet is in flight
        sel = 3'd2;
        set_ch(2, 1'b1, 8'hB1, 1'b0);
        set_ch(0, 1'b1, 8'hC0, 1'b1);
        tick();
        chk("t2_grant_ch", 32'(cur_ch), 32'h2);
        sel = 3'd0;
        tick();
        chk("t2_b1_data", 32'(m_data), 32'hB1);
        chk("t2_b1_ch",   32'(cur_ch), 32'h2);
        set_ch(2, 1'b1, 8'hB2, 1'b0);
        tick();
        chk("t2_b2_data", 32'(m_data), 32'hB2);
        chk("t2_b2_ch",   32'(cur_ch), 32'h2);
        set_ch(2, 1'b1, 8'hB3, 1'b1);
        tick();
        chk("t2_b3_data", 32'(m_data), 32'hB3);
        chk("t2_b3_last", 32'(m_last), 32'h1);
        chk("t2_b3_busy", 32'(busy),   32'h0);
        chk("t2_b3_ch",   32'(cur_ch), 32'h2);
        set_ch(2, 1'b0, 8'h00, 1'b0);
        tick();
        chk("t2_ch0_grant", 32'(cur_ch),  32'h0);
        chk("t2_ch0_busy",  32'(busy),    32'h1);
        chk("t2_ch0_mval",  32'(m_valid), 32'h0);
        tick();
        chk("t2_c0_data", 32'(m_data), 32'hC0);
        chk("t2_c0_last", 32'(m_last), 32'h1);
        set_ch(0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("t2_drain_val", 32'(m_valid), 32'h0);

        // 5-beat packet on ch1 with m_ready low for 4 cycles after beat 1
        sel = 3'd1;
        set_ch(1, 1'b1, dbeat[0], 1'b0);
        tick();
        chk("t3_grant_ch", 32'(cur_ch), 32'h1);
        tick();
        chk("t3_b1_data", 32'(m_data), 32'hD1);
        set_ch(1, 1'b1, dbeat[1], 1'b0);
        m_ready = 1'b0;
        #1;
        chk("t3_bp_ready_now", 32'(s_ready), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t3_hold_data",  32'(m_data),  32'hD1);
            chk("t3_hold_valid", 32'(m_valid), 32'h1);
            chk("t3_hold_ready", 32'(s_ready), 32'h0);
        end
        m_ready = 1'b1;
        #1;
        chk("t3_release_ready", 32'(s_ready), 32'h2);
        for (int b = 1; b < 5; b++) begin
            tick();
            chk("t3_beat_data",  32'(m_data),  32'(dbeat[b]));
            chk("t3_beat_valid", 32'(m_valid), 32'h1);
            chk("t3_beat_last",  32'(m_last),  (b == 4) ? 32'h1 : 32'h0);
            if (b < 4) set_ch(1, 1'b1, dbeat[b+1], (b + 1) == 4);
            else       set_ch(1, 1'b0, 8'h00, 1'b0);
        end
        tick();
        chk("t3_drain_val", 32'(m_valid), 32'h0);

        // reset asserted during beat 2 of a 4-beat packet on ch3
        sel = 3'd3;
        set_ch(3, 1'b1, 8'hF1, 1'b0);
        tick();
        tick();
        chk("t5_b1_data", 32'(m_data), 32'hF1);
        set_ch(3, 1'b1, 8'hF2, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk("t5_async_mval",  32'(m_valid), 32'h0);
        chk("t5_async_ready", 32'(s_ready), 32'h0);
        chk("t5_async_busy",  32'(busy),    32'h0);
        chk("t5_async_ch",    32'(cur_ch),  32'h0);
        chk("t5_async_last",  32'(m_last),  32'h0);
        set_ch(3, 1'b0, 8'h00, 1'b0);
        #2;
        reset = 1'b1;
        sel = 3'd1;
        set_ch(1, 1'b1, 8'h61, 1'b0);
        tick();
        chk("t5_new_ch",   32'(cur_ch), 32'h1);
        chk("t5_new_busy", 32'(busy),   32'h1);
        tick();
        chk("t5_g1_data", 32'(m_data), 32'h61);
        chk("t5_g1_last", 32'(m_last), 32'h0);
        set_ch(1, 1'b1, 8'h62, 1'b1);
        tick();
        chk("t5_g2_data", 32'(m_data), 32'h62);
        chk("t5_g2_last", 32'(m_last), 32'h1);
        chk("t5_g2_busy", 32'(busy),   32'h0);
        set_ch(1, 1'b0, 8'h00, 1'b0);
        tick();
        chk("t5_drain_val", 32'(m_valid), 32'h0);

        // out-of-range sel with every channel requesting
        sel = 3'd4;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 8'(8'h70 + i), 1'b0);
        #1;
        chk("t6_ready_now", 32'(s_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t6_busy",  32'(busy),    32'h0);
            chk("t6_ready", 32'(s_ready), 32'h0);
            chk("t6_mval",  32'(m_valid), 32'h0);
        end
        s_valid = '0;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
